// File: rtl/fdc_host_pkg.sv
// Shared definitions for the FDC host-channel arbiter: command fields,
// host_sr/host_cr bit positions, op encodings and the arbiter state enum.
package fdc_host_pkg;

    localparam int CMD_W       = 19;
    localparam int CMD_OP_LSB  = 17;
    localparam int CMD_DRIVE   = 16;
    localparam int CMD_HEAD    = 15;
    localparam int CMD_CYL_LSB = 8;
    localparam int CMD_SEC_LSB = 0;

    typedef enum logic [1:0] {
        OP_SEEK  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_INV   = 2'b11
    } op_e;

    localparam int SR_ACK = 16;
    localparam int SR_RD0 = 17;
    localparam int SR_RD1 = 18;
    localparam int SR_WR0 = 20;
    localparam int SR_WR1 = 21;
    localparam int SR_SK0 = 24;
    localparam int SR_SK1 = 25;

    localparam int CR_DONE = 4;
    localparam int CR_ERR  = 3;

    // Every request bit lives in [25:17]; completion clears the whole range.
    localparam logic [31:0] SR_REQ_MASK = 32'h03FE_0000;
    localparam logic [31:0] SR_ACK_BIT  = 32'h0001_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        ACK,
        COMPLETE
    } state_e;

    function automatic logic [31:0] sr_req_bit(input op_e op, input logic drive);
        logic [31:0] m;
        m = '0;
        case (op)
            OP_SEEK:  m[drive ? SR_SK1 : SR_SK0] = 1'b1;
            OP_READ:  m[drive ? SR_RD1 : SR_RD0] = 1'b1;
            OP_WRITE: m[drive ? SR_WR1 : SR_WR0] = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fdc_host_arbiter_rr_arb2.sv
// Two-way round-robin pick: when both channels are pending, the one that
// was not served last wins; otherwise the lone pending channel is chosen.
module rr_arb2 (
    input  logic [1:0] pending,
    input  logic       rr,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |pending;
        if (&pending) begin
            pick = ~rr;
        end else begin
            pick = pending[1];
        end
    end

endmodule

// File: rtl/fdc_host_arbiter.sv
// Shares the host disk-service channel between two sector requesters:
// latches requests, grants round-robin, runs the command/ack handshake.
module fdc_host_arbiter
    import fdc_host_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TMO_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [CMD_W-1:0] cmd0,
    input  logic [CMD_W-1:0] cmd1,
    output logic [NREQ-1:0]  busy,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  err,
    output logic [31:0]      host_sr,
    input  logic [31:0]      host_cr
);

    // The increment that lands on all-ones is the one that times out.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_e           state;
    logic [NREQ-1:0]  pending;
    logic [CMD_W-1:0] cmd_q  [NREQ];
    logic [CMD_W-1:0] cmd_in [NREQ];
    logic             g;
    logic             rr;
    logic             result_err;
    logic [TMO_W-1:0] tmo_cnt;
    logic             arb_valid;
    logic             arb_pick;
    logic [CMD_W-1:0] cur_cmd;
    op_e              cur_op;
    logic             unused_cr;

    assign cmd_in[0] = cmd0;
    assign cmd_in[1] = cmd1;
    assign busy      = pending | grant;
    assign cur_cmd   = cmd_q[g];
    assign cur_op    = op_e'(cur_cmd[CMD_OP_LSB +: 2]);
    assign unused_cr = ^{host_cr[31:5], host_cr[2:0]};

    rr_arb2 u_rr_arb2 (
        .pending (pending),
        .rr      (rr),
        .valid   (arb_valid),
        .pick    (arb_pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            grant      <= '0;
            done       <= '0;
            err        <= '0;
            host_sr    <= '0;
            g          <= 1'b0;
            rr         <= 1'b0;
            result_err <= 1'b0;
            tmo_cnt    <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cmd_q[i] <= '0;
            end
        end else begin
            done <= '0;
            err  <= '0;

            // A channel that is pending or granted ignores further strobes.
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !busy[i]) begin
                    pending[i] <= 1'b1;
                    cmd_q[i]   <= cmd_in[i];
                end
            end

            case (state)
                IDLE: begin
                    if (arb_valid && !host_cr[CR_DONE]) begin
                        g     <= arb_pick;
                        grant <= arb_pick ? 2'b10 : 2'b01;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_op == OP_INV) begin
                        err[g] <= 1'b1;
                        state  <= COMPLETE;
                    end else begin
                        host_sr <= sr_req_bit(cur_op, cur_cmd[CMD_DRIVE])
                                 | {16'h0000, cur_cmd[CMD_HEAD:CMD_SEC_LSB]};
                        tmo_cnt <= '0;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (host_cr[CR_DONE]) begin
                        host_sr    <= (host_sr & ~SR_REQ_MASK) | SR_ACK_BIT;
                        result_err <= host_cr[CR_ERR];
                        state      <= ACK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        host_sr <= host_sr & ~SR_REQ_MASK;
                        err[g]  <= 1'b1;
                        state   <= COMPLETE;
                    end
                end
                ACK: begin
                    if (!host_cr[CR_DONE]) begin
                        host_sr[SR_ACK] <= 1'b0;
                        if (result_err) begin
                            err[g] <= 1'b1;
                        end else begin
                            done[g] <= 1'b1;
                        end
                        state <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    pending[g] <= 1'b0;
                    grant      <= '0;
                    rr         <= g;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdc_host_arbiter.sv
// Bench for fdc_host_arbiter: table of single-channel transactions plus
// hand sequences for stale done, reset mid-transaction and contention.
module tb_fdc_host_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [18:0] cmd0;
    logic [18:0] cmd1;
    logic [31:0] host_cr;
    logic [1:0]  busy;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] host_sr;

    typedef struct {
        int          ch;
        logic [18:0] cmd;
        int          delay;
        bit          herr;
        bit          host;
        logic [31:0] exp_sr;
        logic [1:0]  exp_done;
        logic [1:0]  exp_err;
    } vec_t;

    typedef struct {
        int         ch;
        logic [1:0] done;
        logic [1:0] err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   checks      = 0;
    int   errors      = 0;
    int   multi_grant = 0;

    always #5 clk = ~clk;

    fdc_host_arbiter #(.NREQ(2), .TMO_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .cmd0    (cmd0),
        .cmd1    (cmd1),
        .busy    (busy),
        .grant   (grant),
        .done    (done),
        .err     (err),
        .host_sr (host_sr),
        .host_cr (host_cr)
    );

    always @(negedge clk) begin
        if ($countones(grant) > 1) multi_grant++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [18:0] cmd,
                                 input logic [1:0] exp_done, input logic [1:0] exp_err);
        if (ch == 0) cmd0 = cmd; else cmd1 = cmd;
        req = (ch == 1) ? 2'b10 : 2'b01;
        sb.push_back('{ch, exp_done, exp_err});
        @(negedge clk);
        req = 2'b00;
    endtask

    task automatic checkOutput(output int ch);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got pulse done=%b err=%b expected none", done, err);
            ch = 0;
        end else begin
            e = sb.pop_front();
            check("done_pulse", {30'd0, done}, {30'd0, e.done});
            check("err_pulse", {30'd0, err}, {30'd0, e.err});
            ch = e.ch;
        end
    endtask

    // Plays the host side of one transaction, then checks the completion pulse.
    task automatic serveHost(input logic [31:0] exp_sr, input int delay, input bit herr,
                             input bit host, input bit wait_req, input bit req_in_pulse);
        int n;
        int ch;
        if (host) begin
            if (wait_req) begin
                n = 0;
                while (host_sr[25:17] == 9'd0 && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                check("host_sr_issue", host_sr, exp_sr);
            end
            if (delay >= 0) begin
                repeat (delay) @(negedge clk);
                host_cr = herr ? 32'h0000_0018 : 32'h0000_0010;
                n = 0;
                while (!host_sr[16] && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                check("ack_set", {31'd0, host_sr[16]}, 32'd1);
                check("req_bits_cleared_in_ack", {23'd0, host_sr[25:17]}, 32'd0);
                @(negedge clk);
                check("ack_held", {31'd0, host_sr[16]}, 32'd1);
                host_cr = 32'd0;
            end
        end
        n = 0;
        while ((done | err) == 2'b00 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if ((done | err) == 2'b00) begin
            check("pulse_seen", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (host && delay < 0) check("timeout_latency", n, 32'd15);
        check("host_sr_req_ack_idle", {22'd0, host_sr[25:16]}, 32'd0);
        checkOutput(ch);
        if (req_in_pulse) req = (ch == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        req = 2'b00;
        check("busy_fall", {31'd0, busy[ch]}, 32'd0);
        check("pulse_single_cycle", {28'd0, done, err}, 32'd0);
        if (req_in_pulse) begin
            @(negedge clk);
            check("req_in_pulse_ignored", {31'd0, busy[ch]}, 32'd0);
        end
    endtask

    initial begin
        int pulses;
        vec_t v;

        vecs[0] = '{0, {2'b01, 1'b0, 1'b1, 7'd5,   8'hC3}, 10, 1'b0, 1'b1, 32'h0002_85C3, 2'b01, 2'b00};
        vecs[1] = '{1, {2'b10, 1'b1, 1'b0, 7'h22,  8'h07},  6, 1'b1, 1'b1, 32'h0020_2207, 2'b00, 2'b10};
        vecs[2] = '{0, {2'b00, 1'b1, 1'b1, 7'h7F,  8'hFF},  3, 1'b0, 1'b1, 32'h0200_FFFF, 2'b01, 2'b00};
        vecs[3] = '{1, {2'b01, 1'b1, 1'b0, 7'd0,   8'h01},  0, 1'b0, 1'b1, 32'h0004_0001, 2'b10, 2'b00};
        vecs[4] = '{0, {2'b10, 1'b0, 1'b1, 7'd1,   8'h00},  5, 1'b0, 1'b1, 32'h0010_8100, 2'b01, 2'b00};
        vecs[5] = '{1, {2'b00, 1'b0, 1'b0, 7'd3,   8'h10},  2, 1'b1, 1'b1, 32'h0100_0310, 2'b00, 2'b10};
        vecs[6] = '{1, {2'b01, 1'b0, 1'b0, 7'd9,   8'h09}, -1, 1'b0, 1'b1, 32'h0002_0909, 2'b00, 2'b10};
        vecs[7] = '{0, {2'b11, 1'b0, 1'b0, 7'd0,   8'h00},  0, 1'b0, 1'b0, 32'h0000_0000, 2'b00, 2'b01};
        vecs[8] = '{1, {2'b10, 1'b0, 1'b1, 7'd2,   8'h2A},  4, 1'b0, 1'b1, 32'h0010_822A, 2'b10, 2'b00};

        rst_n   = 1'b0;
        req     = 2'b00;
        cmd0    = '0;
        cmd1    = '0;
        host_cr = '0;
        repeat (3) @(negedge clk);
        check("reset_host_sr", host_sr, 32'd0);
        check("reset_busy", {30'd0, busy}, 32'd0);
        check("reset_grant", {30'd0, grant}, 32'd0);
        check("reset_pulses", {28'd0, done, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            applyStimulus(v.ch, v.cmd, v.exp_done, v.exp_err);
            check("busy_after_req", {31'd0, busy[v.ch]}, 32'd1);
            check("grant_not_yet", {30'd0, grant}, 32'd0);
            @(negedge clk);
            check("grant_onehot", {30'd0, grant}, (v.ch == 1) ? 32'd2 : 32'd1);
            @(negedge clk);
            if (v.host) check("host_sr_latency", host_sr, v.exp_sr);
            else        check("host_sr_inv_quiet", {22'd0, host_sr[25:16]}, 32'd0);
            serveHost(v.exp_sr, v.delay, v.herr, v.host, 1'b0, i == 0);
        end

        // Stale done: no grant while host_cr[4] stays high.
        host_cr = 32'h0000_0010;
        applyStimulus(0, {2'b01, 1'b1, 1'b0, 7'd6, 8'h11}, 2'b01, 2'b00);
        repeat (5) @(negedge clk);
        check("stale_no_grant", {30'd0, grant}, 32'd0);
        check("stale_busy", {30'd0, busy}, 32'd1);
        host_cr = 32'd0;
        serveHost(32'h0004_0611, 2, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset while waiting for the host.
        cmd0 = {2'b01, 1'b0, 1'b0, 7'd7, 8'h07};
        req  = 2'b01;
        @(negedge clk);
        req = 2'b00;
        repeat (4) @(negedge clk);
        check("rst_pre_active", {31'd0, host_sr[25:17] != 9'd0}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_host_sr", host_sr, 32'd0);
        check("rst_mid_busy", {30'd0, busy}, 32'd0);
        check("rst_mid_grant", {30'd0, grant}, 32'd0);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if ((done | err) != 2'b00) pulses++;
        end
        check("rst_mid_no_pulse", pulses, 32'd0);

        // Contention right after reset: rr=0, so channel 1 goes first.
        cmd0 = {2'b01, 1'b0, 1'b0, 7'd2, 8'h02};
        cmd1 = {2'b10, 1'b0, 1'b0, 7'd4, 8'h04};
        req  = 2'b11;
        sb.push_back('{1, 2'b10, 2'b00});
        sb.push_back('{0, 2'b01, 2'b00});
        @(negedge clk);
        req = 2'b00;
        serveHost(32'h0010_0404, 4, 1'b0, 1'b1, 1'b1, 1'b0);
        serveHost(32'h0002_0202, 4, 1'b0, 1'b1, 1'b1, 1'b0);

        check("grant_never_multi", multi_grant, 32'd0);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
